// File: rtl/cache_store_buffer.sv
// cache_store_buffer
// In-order store buffer between the core and the cache controller.
// Writes are queued in a circular FIFO and drained, oldest first, to the
// cache request port. Reads that hit a queued full-word write are answered
// locally from the youngest matching entry. Reads that miss every entry go to
// the cache. Reads that hit a partially masked entry stall until it drains.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/ready/we/addr/
//   req_wdata/wmask               core request (valid/ready handshake)
//   resp_valid/resp_data          read response, one-cycle pulse
//   mem_req_valid/ready/we/addr/
//   mem_req_wdata/wmask           request to cache controller
//   mem_resp_valid/mem_resp_data  cache read data
//   sb_empty/sb_count             buffer occupancy (registered state)
module cache_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  input  logic [DATA_W/8-1:0]        req_wmask,
  output logic                       resp_valid,
  output logic [DATA_W-1:0]          resp_data,
  output logic                       mem_req_valid,
  input  logic                       mem_req_ready,
  output logic                       mem_req_we,
  output logic [ADDR_W-1:0]          mem_req_addr,
  output logic [DATA_W-1:0]          mem_req_wdata,
  output logic [DATA_W/8-1:0]        mem_req_wmask,
  input  logic                       mem_resp_valid,
  input  logic [DATA_W-1:0]          mem_resp_data,
  output logic                       sb_empty,
  output logic [$clog2(DEPTH):0]     sb_count
);

  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ISSUE = 2'd1,
    RD_WAIT  = 2'd2
  } state_t;

  state_t              state_r, state_next_s;
  logic [ADDR_W-1:0]   addr_r [DEPTH];
  logic [DATA_W-1:0]   data_r [DEPTH];
  logic [MASK_W-1:0]   mask_r [DEPTH];
  logic [PTR_W-1:0]    head_r, tail_r;
  logic [CNT_W-1:0]    count_r;
  logic                drain_pending_r;
  logic [ADDR_W-1:0]   rd_addr_r;
  logic                resp_valid_r;
  logic [DATA_W-1:0]   resp_data_r;

  logic                hit_s;
  logic [PTR_W-1:0]    hit_idx_s;
  logic                req_ready_s;
  logic                mem_req_valid_s, mem_req_we_s;
  logic [ADDR_W-1:0]   mem_req_addr_s;
  logic [DATA_W-1:0]   mem_req_wdata_s;
  logic [MASK_W-1:0]   mem_req_wmask_s;
  logic                push_s, pop_s, fwd_s, rd_start_s;

  function automatic logic is_full_mask(input logic [MASK_W-1:0] m);
    return &m;
  endfunction

  // Youngest-match lookup: scan oldest to youngest so later matches win.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic             match_v;
      logic [PTR_W-1:0] idx_v;
      idx_v     = head_r + PTR_W'(i);
      match_v   = (CNT_W'(i) < count_r) && (addr_r[idx_v] == req_addr);
      hit_s     = hit_s | match_v;
      hit_idx_s = match_v ? idx_v : hit_idx_s;
    end
  end

  // Next state, upstream ready and cache request mux.
  always_comb begin
    state_next_s    = state_r;
    req_ready_s     = 1'b0;
    mem_req_valid_s = 1'b0;
    mem_req_we_s    = 1'b0;
    mem_req_addr_s  = '0;
    mem_req_wdata_s = '0;
    mem_req_wmask_s = '0;
    case (state_r)
      IDLE: begin
        if (req_we) begin
          req_ready_s = (count_r < CNT_FULL);
        end else begin
          req_ready_s = !(hit_s && !is_full_mask(mask_r[hit_idx_s]));
        end
        if (count_r != '0) begin
          mem_req_valid_s = 1'b1;
          mem_req_we_s    = 1'b1;
          mem_req_addr_s  = addr_r[head_r];
          mem_req_wdata_s = data_r[head_r];
          mem_req_wmask_s = mask_r[head_r];
        end else begin
          mem_req_valid_s = 1'b0;
        end
        if (req_valid && req_ready_s && !req_we && !hit_s) begin
          state_next_s = RD_ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      RD_ISSUE: begin
        // A drain beat already offered is finished before the read goes out.
        if (drain_pending_r) begin
          mem_req_valid_s = 1'b1;
          mem_req_we_s    = 1'b1;
          mem_req_addr_s  = addr_r[head_r];
          mem_req_wdata_s = data_r[head_r];
          mem_req_wmask_s = mask_r[head_r];
          state_next_s    = RD_ISSUE;
        end else begin
          mem_req_valid_s = 1'b1;
          mem_req_addr_s  = rd_addr_r;
          if (mem_req_ready) begin
            state_next_s = RD_WAIT;
          end else begin
            state_next_s = RD_ISSUE;
          end
        end
      end
      RD_WAIT: begin
        if (mem_resp_valid) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RD_WAIT;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  assign push_s     = req_valid && req_ready_s && req_we;
  assign fwd_s      = req_valid && req_ready_s && !req_we && hit_s;
  assign rd_start_s = req_valid && req_ready_s && !req_we && !hit_s;
  assign pop_s      = mem_req_valid_s && mem_req_ready && mem_req_we_s;

  // FSM state, stalled-drain flag and the captured read address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      drain_pending_r <= 1'b0;
      rd_addr_r       <= '0;
    end else begin
      state_r         <= state_next_s;
      drain_pending_r <= mem_req_valid_s && mem_req_we_s && !mem_req_ready;
      if (rd_start_s) begin
        rd_addr_r <= req_addr;
      end else begin
        rd_addr_r <= rd_addr_r;
      end
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= '0;
        data_r[i] <= '0;
        mask_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        addr_r[tail_r] <= req_addr;
        data_r[tail_r] <= req_wdata;
        mask_r[tail_r] <= req_wmask;
        tail_r         <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Read response register: forwarded data or cache data, one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      resp_data_r  <= '0;
    end else if (fwd_s) begin
      resp_valid_r <= 1'b1;
      resp_data_r  <= data_r[hit_idx_s];
    end else if ((state_r == RD_WAIT) && mem_resp_valid) begin
      resp_valid_r <= 1'b1;
      resp_data_r  <= mem_resp_data;
    end else begin
      resp_valid_r <= 1'b0;
    end
  end

  assign req_ready     = req_ready_s;
  assign resp_valid    = resp_valid_r;
  assign resp_data     = resp_data_r;
  assign mem_req_valid = mem_req_valid_s;
  assign mem_req_we    = mem_req_we_s;
  assign mem_req_addr  = mem_req_addr_s;
  assign mem_req_wdata = mem_req_wdata_s;
  assign mem_req_wmask = mem_req_wmask_s;
  assign sb_empty      = (count_r == '0);
  assign sb_count      = count_r;

endmodule

// File: tb/tb_cache_store_buffer.sv
// Self-checking bench for cache_store_buffer (DEPTH=4, 32-bit address/data).
// Inputs change 2 time units after the rising edge; a negedge monitor
// scores cache requests and read responses against queues of expectations.
module tb_cache_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        sb_empty;
  logic [2:0]  sb_count;

  cache_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .sb_empty(sb_empty), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } wr_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        exp_ready;
    logic [2:0]  exp_count;
  } vec_t;

  wr_t         drain_q[$];
  logic [31:0] rdq_q[$];
  logic [31:0] resp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int rd_seen = 0;
  int rd_served = 0;
  int drains_done = 0;
  int rd_issue_drains = 0;
  int resp_seen = 0;
  logic        hold_resp = 1'b0;
  logic [31:0] mem_rd_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Hold a request until accepted (bounded), then drop req_valid.
  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
    n = 0;
    #1;
    while (!req_ready && n < 40) begin
      cyc();
      #1;
      n++;
    end
    if (!req_ready) check("send_timeout", 32'd1, 32'd0);
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (!(sb_empty && drain_q.size() == 0) && n < 60) begin
      cyc();
      n++;
    end
    check("wait_empty", {31'd0, sb_empty}, 32'd1);
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (resp_q.size() != 0 && n < 40) begin
      cyc();
      n++;
    end
    check("wait_resp", resp_q.size(), 32'd0);
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready && req_we)
        drain_q.push_back({req_addr, req_wdata, req_wmask});
      if (mem_req_valid && mem_req_ready) begin
        if (mem_req_we) begin
          if (drain_q.size() == 0) begin
            check("unexpected_drain", mem_req_addr, 32'hFFFF_FFFF);
          end else begin
            wr_t e;
            e = drain_q.pop_front();
            check("drain_addr", mem_req_addr, e.a);
            check("drain_data", mem_req_wdata, e.d);
            check("drain_mask", {28'd0, mem_req_wmask}, {28'd0, e.m});
          end
          drains_done++;
        end else begin
          rd_seen++;
          rd_issue_drains = drains_done;
          if (rdq_q.size() == 0) check("unexpected_mem_read", mem_req_addr, 32'hFFFF_FFFF);
          else check("mem_read_addr", mem_req_addr, rdq_q.pop_front());
        end
      end
      if (resp_valid) begin
        resp_seen++;
        if (resp_q.size() == 0) check("unexpected_resp", resp_data, 32'hFFFF_FFFF);
        else check("resp_data", resp_data, resp_q.pop_front());
      end
    end
  end

  // Cache read responder: one cycle after each read handshake.
  initial begin
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (!hold_resp && rd_seen > rd_served) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = mem_rd_data;
        rd_served++;
      end else begin
        mem_resp_valid = 1'b0;
      end
    end
  end

  initial begin
    vec_t vecs[7];
    int   rd_before, e_base, resp_before;

    vecs[0] = '{1'b1, 32'h100, 32'hA000_0100, 4'hF, 1'b1, 3'd0};
    vecs[1] = '{1'b1, 32'h101, 32'hA000_0101, 4'hF, 1'b1, 3'd1};
    vecs[2] = '{1'b1, 32'h102, 32'hA000_0102, 4'hF, 1'b1, 3'd2};
    vecs[3] = '{1'b1, 32'h103, 32'hA000_0103, 4'hF, 1'b1, 3'd3};
    vecs[4] = '{1'b1, 32'h104, 32'hA000_0104, 4'hF, 1'b0, 3'd4};
    vecs[5] = '{1'b0, 32'h102, 32'hA000_0102, 4'h0, 1'b1, 3'd4};
    vecs[6] = '{1'b0, 32'h100, 32'hA000_0100, 4'h0, 1'b1, 3'd4};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; mem_req_ready = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    #1;
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check("rst_sb_empty", {31'd0, sb_empty}, 32'd1);
    check("rst_sb_count", {29'd0, sb_count}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_mem_req_addr", mem_req_addr, 32'd0);

    // Full-word write then back-to-back read: forwarded, no cache read.
    mem_req_ready = 1'b1;
    rd_before = rd_seen;
    send(1'b1, 32'h1F0, 32'hDEAD_BEEF, 4'hF);
    resp_q.push_back(32'hDEAD_BEEF);
    send(1'b0, 32'h1F0, 32'h0, 4'h0);
    wait_resp();
    wait_empty();
    check("a_no_mem_read", rd_seen, rd_before);

    // Two writes to one address, read forwards the youngest.
    mem_req_ready = 1'b0;
    send(1'b1, 32'h1F0, 32'h0000_000A, 4'hF);
    send(1'b1, 32'h1F0, 32'h0000_000B, 4'hF);
    resp_q.push_back(32'h0000_000B);
    send(1'b0, 32'h1F0, 32'h0, 4'h0);
    wait_resp();
    mem_req_ready = 1'b1;
    wait_empty();

    // Partial-mask hit stalls the read until the entry drains.
    mem_req_ready = 1'b0;
    send(1'b1, 32'h1F1, 32'hCAFE_BABE, 4'h3);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h1F1;
    #1;
    check("c_stall_0", {31'd0, req_ready}, 32'd0);
    cyc();
    #1;
    check("c_stall_1", {31'd0, req_ready}, 32'd0);
    rdq_q.push_back(32'h1F1);
    resp_q.push_back(32'h0000_BABE);
    mem_rd_data = 32'h0000_BABE;
    mem_req_ready = 1'b1;
    send(1'b0, 32'h1F1, 32'h0, 4'h0);
    wait_resp();
    wait_empty();

    // Table: fill to full with the cache stalled, then forward from a full buffer.
    mem_req_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      req_valid = 1'b1; req_we = vecs[i].we; req_addr = vecs[i].addr;
      req_wdata = vecs[i].data; req_wmask = vecs[i].mask;
      #1;
      check("tbl_ready", {31'd0, req_ready}, {31'd0, vecs[i].exp_ready});
      check("tbl_count", {29'd0, sb_count}, {29'd0, vecs[i].exp_count});
      if (req_ready && !vecs[i].we) resp_q.push_back(vecs[i].data);
      cyc();
    end
    req_valid = 1'b0;
    wait_resp();
    mem_req_ready = 1'b1;
    wait_empty();
    send(1'b1, 32'h104, 32'hA000_0104, 4'hF);
    wait_empty();

    // Second full fill across the pointer wrap.
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(1'b1, 32'h300 + 32'(i), 32'hB000_0300 + 32'(i), 4'hF);
    #1;
    check("wrap_count", {29'd0, sb_count}, 32'd4);
    resp_q.push_back(32'hB000_0303);
    send(1'b0, 32'h303, 32'h0, 4'h0);
    wait_resp();
    mem_req_ready = 1'b1;
    wait_empty();

    // Read miss overtakes queued drains after the in-flight beat.
    mem_req_ready = 1'b0;
    e_base = drains_done;
    send(1'b1, 32'h210, 32'h0000_0210, 4'hF);
    send(1'b1, 32'h211, 32'h0000_0211, 4'hF);
    rdq_q.push_back(32'h200);
    resp_q.push_back(32'h1234_5678);
    mem_rd_data = 32'h1234_5678;
    send(1'b0, 32'h200, 32'h0, 4'h0);
    mem_req_ready = 1'b1;
    wait_resp();
    wait_empty();
    check("e_read_before_drains", rd_issue_drains - e_base, 32'd1);
    check("e_queues_empty", drain_q.size() + rdq_q.size(), 32'd0);

    // Reset while waiting on the cache with three entries queued.
    mem_req_ready = 1'b0;
    hold_resp = 1'b1;
    for (int i = 0; i < 4; i++)
      send(1'b1, 32'h400 + 32'(i), 32'hC000_0400 + 32'(i), 4'hF);
    rdq_q.push_back(32'h500);
    mem_rd_data = 32'h5555_AAAA;
    send(1'b0, 32'h500, 32'h0, 4'h0);
    mem_req_ready = 1'b1;
    cyc();
    cyc();
    mem_req_ready = 1'b0;
    #1;
    check("f_wait_count", {29'd0, sb_count}, 32'd3);
    check("f_wait_no_mem_req", {31'd0, mem_req_valid}, 32'd0);
    rst = 1'b1;
    cyc();
    drain_q.delete();
    #1;
    check("f_rst_sb_empty", {31'd0, sb_empty}, 32'd1);
    check("f_rst_sb_count", {29'd0, sb_count}, 32'd0);
    check("f_rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    rst = 1'b0;
    resp_before = resp_seen;
    hold_resp = 1'b0;
    repeat (5) cyc();
    check("f_late_resp_ignored", resp_seen, resp_before);
    check("f_served_late", rd_served, rd_seen);
    check("f_still_empty", {29'd0, sb_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
